interrupt_controller: RTL and testbench

//   Arbitrates the five interrupt sources (VBlank 0x40, LCD STAT 0x48, Timer 0x50,

---
 rtl/interrupt_controller_if.sv | 32 +++
 rtl/interrupt_controller.sv | 131 +++++++++++++
 tb/tb_interrupt_controller.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_if.sv
// CPU/MCU-facing bundle of the interrupt controller: source pulses, register
// writes, instruction-boundary info, and the dispatch request/acknowledge pair.
interface interrupt_controller_if #(
  parameter int NUM_SOURCES = 5
);
  logic [NUM_SOURCES-1:0] iSources;
  logic                   iMcuWe;
  logic [3:0]             iMcuRegSelect;
  logic                   iIeWe;
  logic [7:0]             iMcuWriteData;
  logic                   iEof;
  logic [7:0]             iOpcode;
  logic                   iAck;
  logic [7:0]             oIf;
  logic [7:0]             oIe;
  logic                   oIme;
  logic                   oIrqRequest;
  logic [7:0]             oIrqVector;
  logic                   oWakeup;

  modport master (
    output iSources, iMcuWe, iMcuRegSelect, iIeWe, iMcuWriteData,
           iEof, iOpcode, iAck,
    input  oIf, oIe, oIme, oIrqRequest, oIrqVector, oWakeup
  );

  modport slave (
    input  iSources, iMcuWe, iMcuRegSelect, iIeWe, iMcuWriteData,
           iEof, iOpcode, iAck,
    output oIf, oIe, oIme, oIrqRequest, oIrqVector, oWakeup
  );
endinterface

// File: rtl/interrupt_controller.sv
// Interrupt controller: owns IF/IE/IME, arbitrates pending sources at instruction
// boundaries and hands one latched vector to the CPU via request/acknowledge.
module interrupt_controller #(
  parameter int         NUM_SOURCES   = 5,
  parameter logic [7:0] VECTOR_BASE   = 8'h40,
  parameter logic [7:0] VECTOR_STRIDE = 8'h08
) (
  input  logic                  iClock,
  input  logic                  iReset,
  interrupt_controller_if.slave bus
);

  localparam int         IDX_W   = $clog2(NUM_SOURCES);
  localparam logic [7:0] OP_EI   = 8'hFB;
  localparam logic [7:0] OP_DI   = 8'hF3;
  localparam logic [7:0] OP_RETI = 8'hD9;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t                 stateQ, stateD;
  logic [NUM_SOURCES-1:0] ifQ, ifD;
  logic [7:0]             ieQ, ieD;
  logic                   imeQ, imeD;
  logic                   eiPendingQ, eiPendingD;
  logic [IDX_W-1:0]       idxQ, idxD;
  logic [7:0]             vectorQ, vectorD;

  logic [NUM_SOURCES-1:0] pending;
  logic [NUM_SOURCES-1:0] setMask;
  logic [NUM_SOURCES-1:0] clrMask;
  logic [NUM_SOURCES-1:0] ackMask;
  logic [IDX_W-1:0]       grantIdx;
  logic                   ackFire;
  logic                   ifWrite;
  logic                   imeEligible;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      stateQ     <= IDLE;
      ifQ        <= '0;
      ieQ        <= '0;
      imeQ       <= 1'b0;
      eiPendingQ <= 1'b0;
      idxQ       <= '0;
      vectorQ    <= '0;
    end else begin
      stateQ     <= stateD;
      ifQ        <= ifD;
      ieQ        <= ieD;
      imeQ       <= imeD;
      eiPendingQ <= eiPendingD;
      idxQ       <= idxD;
      vectorQ    <= vectorD;
    end
  end

  always_comb begin
    stateD     = stateQ;
    idxD       = idxQ;
    vectorD    = vectorQ;
    imeD       = imeQ;
    eiPendingD = eiPendingQ;
    ieD        = bus.iIeWe ? bus.iMcuWriteData : ieQ;

    pending = ifQ & ieQ[NUM_SOURCES-1:0];
    ackFire = (stateQ == REQ) && bus.iAck;
    ifWrite = bus.iMcuWe && (bus.iMcuRegSelect == 4'hF);

    // Sets are OR-ed in last so a same-cycle source pulse beats any clear.
    ackMask = '0;
    if (ackFire) ackMask[idxQ] = 1'b1;
    setMask = bus.iSources;
    clrMask = ackMask;
    if (ifWrite) begin
      setMask = setMask | bus.iMcuWriteData[NUM_SOURCES-1:0];
      clrMask = clrMask | ~bus.iMcuWriteData[NUM_SOURCES-1:0];
    end
    ifD = (ifQ & ~clrMask) | setMask;

    if (bus.iEof) begin
      if (eiPendingQ) begin
        imeD       = 1'b1;
        eiPendingD = 1'b0;
      end
      case (bus.iOpcode)
        OP_EI:   eiPendingD = 1'b1;
        OP_DI: begin
          imeD       = 1'b0;
          eiPendingD = 1'b0;
        end
        OP_RETI: imeD = 1'b1;
        default: ;
      endcase
    end
    if (ackFire) begin
      imeD       = 1'b0;
      eiPendingD = 1'b0;
    end

    // A matured EI counts as enabled for this boundary unless the retiring opcode is DI.
    imeEligible = imeQ || (eiPendingQ && (bus.iOpcode != OP_DI));

    grantIdx = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (pending[i]) grantIdx = IDX_W'(i);
    end

    case (stateQ)
      IDLE: begin
        if (bus.iEof && imeEligible && (|pending)) begin
          stateD  = REQ;
          idxD    = grantIdx;
          vectorD = VECTOR_BASE + 8'(grantIdx) * VECTOR_STRIDE;
        end
      end
      REQ: begin
        if (ackFire) stateD = SERVICE;
      end
      SERVICE: stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  assign bus.oIf         = {{(8 - NUM_SOURCES){1'b1}}, ifQ};
  assign bus.oIe         = ieQ;
  assign bus.oIme        = imeQ;
  assign bus.oIrqRequest = (stateQ == REQ);
  assign bus.oIrqVector  = vectorQ;
  assign bus.oWakeup     = |pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: dispatch, priority, EI delay, committed
// requests, set-wins and reset behaviour, each with hand-computed expectations.
module tb_interrupt_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   testsRun = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  interrupt_controller_if bus ();

  interrupt_controller dut (
    .iClock (clk),
    .iReset (rst),
    .bus    (bus)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.iSources      = '0;
    bus.iMcuWe        = 1'b0;
    bus.iMcuRegSelect = 4'h0;
    bus.iIeWe         = 1'b0;
    bus.iMcuWriteData = 8'h00;
    bus.iEof          = 1'b0;
    bus.iOpcode       = 8'h00;
    bus.iAck          = 1'b0;
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic eof(input logic [7:0] op);
    bus.iEof = 1'b1;
    bus.iOpcode = op;
    cycle();
    bus.iEof = 1'b0;
    bus.iOpcode = 8'h00;
  endtask

  task automatic pulseSrc(input logic [4:0] s);
    bus.iSources = s;
    cycle();
    bus.iSources = '0;
  endtask

  task automatic writeIe(input logic [7:0] v);
    bus.iIeWe = 1'b1;
    bus.iMcuWriteData = v;
    cycle();
    bus.iIeWe = 1'b0;
  endtask

  task automatic writeReg(input logic [3:0] sel, input logic [7:0] v);
    bus.iMcuWe = 1'b1;
    bus.iMcuRegSelect = sel;
    bus.iMcuWriteData = v;
    cycle();
    bus.iMcuWe = 1'b0;
    bus.iMcuRegSelect = 4'h0;
  endtask

  task automatic ackPulse();
    bus.iAck = 1'b1;
    cycle();
    bus.iAck = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    testsRun++;
    if (bus.oIf !== 8'hE0) begin testsFailed++; $display("[TB] FAIL reset_if got %h want e0", bus.oIf); end
    testsRun++;
    if (bus.oIe !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_ie got %h want 00", bus.oIe); end
    testsRun++;
    if ({bus.oIme, bus.oIrqRequest, bus.oWakeup} !== 3'b000) begin
      testsFailed++; $display("[TB] FAIL reset_flags got %b want 000", {bus.oIme, bus.oIrqRequest, bus.oWakeup});
    end
    testsRun++;
    if (bus.oIrqVector !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_vector got %h want 00", bus.oIrqVector); end
  endtask

  task automatic test_timer_dispatch();
    doReset();
    writeIe(8'h04);
    eof(8'hD9);
    testsRun++;
    if (bus.oIme !== 1'b1) begin testsFailed++; $display("[TB] FAIL reti_ime got %b want 1", bus.oIme); end
    pulseSrc(5'b00100);
    testsRun++;
    if ({bus.oIf, bus.oWakeup, bus.oIrqRequest} !== {8'hE4, 1'b1, 1'b0}) begin
      testsFailed++; $display("[TB] FAIL timer_pending got if=%h wake=%b req=%b want e4 1 0", bus.oIf, bus.oWakeup, bus.oIrqRequest);
    end
    eof(8'h00);
    testsRun++;
    if ({bus.oIrqRequest, bus.oIrqVector} !== {1'b1, 8'h50}) begin
      testsFailed++; $display("[TB] FAIL timer_req got req=%b vec=%h want 1 50", bus.oIrqRequest, bus.oIrqVector);
    end
    ackPulse();
    testsRun++;
    if ({bus.oIf, bus.oIme, bus.oIrqRequest} !== {8'hE0, 1'b0, 1'b0}) begin
      testsFailed++; $display("[TB] FAIL timer_ack got if=%h ime=%b req=%b want e0 0 0", bus.oIf, bus.oIme, bus.oIrqRequest);
    end
    cycle();
    testsRun++;
    if (bus.oIrqRequest !== 1'b0) begin testsFailed++; $display("[TB] FAIL timer_idle got req=%b want 0", bus.oIrqRequest); end
  endtask

  task automatic test_priority();
    doReset();
    writeIe(8'h1F);
    eof(8'hD9);
    pulseSrc(5'b10110);
    testsRun++;
    if (bus.oIf !== 8'hF6) begin testsFailed++; $display("[TB] FAIL prio_if got %h want f6", bus.oIf); end
    eof(8'h00);
    testsRun++;
    if ({bus.oIrqRequest, bus.oIrqVector} !== {1'b1, 8'h48}) begin
      testsFailed++; $display("[TB] FAIL prio_vec got req=%b vec=%h want 1 48", bus.oIrqRequest, bus.oIrqVector);
    end
    ackPulse();
    testsRun++;
    if (bus.oIf !== 8'hF4) begin testsFailed++; $display("[TB] FAIL prio_ack_if got %h want f4", bus.oIf); end
    cycle();
    eof(8'h00);
    testsRun++;
    if (bus.oIrqRequest !== 1'b0) begin testsFailed++; $display("[TB] FAIL prio_ime_off got req=%b want 0", bus.oIrqRequest); end
    eof(8'hD9);
    testsRun++;
    if ({bus.oIrqRequest, bus.oIme} !== 2'b01) begin
      testsFailed++; $display("[TB] FAIL prio_reti_boundary got req=%b ime=%b want 0 1", bus.oIrqRequest, bus.oIme);
    end
    eof(8'h00);
    testsRun++;
    if ({bus.oIrqRequest, bus.oIrqVector} !== {1'b1, 8'h50}) begin
      testsFailed++; $display("[TB] FAIL prio_second got req=%b vec=%h want 1 50", bus.oIrqRequest, bus.oIrqVector);
    end
    ackPulse();
  endtask

  task automatic test_ei_delay();
    doReset();
    writeIe(8'h01);
    pulseSrc(5'b00001);
    eof(8'hFB);
    testsRun++;
    if ({bus.oIrqRequest, bus.oIme} !== 2'b00) begin
      testsFailed++; $display("[TB] FAIL ei_first got req=%b ime=%b want 0 0", bus.oIrqRequest, bus.oIme);
    end
    eof(8'h00);
    testsRun++;
    if ({bus.oIrqRequest, bus.oIrqVector, bus.oIme} !== {1'b1, 8'h40, 1'b1}) begin
      testsFailed++; $display("[TB] FAIL ei_second got req=%b vec=%h ime=%b want 1 40 1", bus.oIrqRequest, bus.oIrqVector, bus.oIme);
    end
    ackPulse();
    doReset();
    writeIe(8'h01);
    pulseSrc(5'b00001);
    eof(8'hFB);
    eof(8'hF3);
    testsRun++;
    if ({bus.oIrqRequest, bus.oIme} !== 2'b00) begin
      testsFailed++; $display("[TB] FAIL ei_di got req=%b ime=%b want 0 0", bus.oIrqRequest, bus.oIme);
    end
    eof(8'h00);
    testsRun++;
    if (bus.oIrqRequest !== 1'b0) begin testsFailed++; $display("[TB] FAIL ei_di_after got req=%b want 0", bus.oIrqRequest); end
  endtask

  task automatic test_committed();
    doReset();
    writeIe(8'h04);
    eof(8'hD9);
    pulseSrc(5'b00100);
    eof(8'h00);
    pulseSrc(5'b00001);
    writeIe(8'h00);
    testsRun++;
    if ({bus.oIrqRequest, bus.oIrqVector, bus.oIe} !== {1'b1, 8'h50, 8'h00}) begin
      testsFailed++; $display("[TB] FAIL commit_hold got req=%b vec=%h ie=%h want 1 50 00", bus.oIrqRequest, bus.oIrqVector, bus.oIe);
    end
    ackPulse();
    testsRun++;
    if ({bus.oIf, bus.oIrqRequest} !== {8'hE1, 1'b0}) begin
      testsFailed++; $display("[TB] FAIL commit_ack got if=%h req=%b want e1 0", bus.oIf, bus.oIrqRequest);
    end
  endtask

  task automatic test_set_wins();
    doReset();
    writeIe(8'h04);
    eof(8'hD9);
    pulseSrc(5'b00100);
    eof(8'h00);
    bus.iAck = 1'b1;
    bus.iSources = 5'b00100;
    cycle();
    bus.iAck = 1'b0;
    bus.iSources = '0;
    testsRun++;
    if ({bus.oIf, bus.oIme, bus.oIrqRequest} !== {8'hE4, 1'b0, 1'b0}) begin
      testsFailed++; $display("[TB] FAIL setwins_ack got if=%h ime=%b req=%b want e4 0 0", bus.oIf, bus.oIme, bus.oIrqRequest);
    end
    bus.iSources = 5'b01000;
    writeReg(4'hF, 8'h00);
    bus.iSources = '0;
    testsRun++;
    if (bus.oIf !== 8'hE8) begin testsFailed++; $display("[TB] FAIL setwins_write got %h want e8", bus.oIf); end
    writeReg(4'h3, 8'hFF);
    testsRun++;
    if (bus.oIf !== 8'hE8) begin testsFailed++; $display("[TB] FAIL if_select got %h want e8", bus.oIf); end
    writeReg(4'hF, 8'h13);
    testsRun++;
    if (bus.oIf !== 8'hF3) begin testsFailed++; $display("[TB] FAIL if_write got %h want f3", bus.oIf); end
    ackPulse();
    testsRun++;
    if ({bus.oIf, bus.oIrqRequest} !== {8'hF3, 1'b0}) begin
      testsFailed++; $display("[TB] FAIL stray_ack got if=%h req=%b want f3 0", bus.oIf, bus.oIrqRequest);
    end
  endtask

  task automatic test_reset_mid_request();
    doReset();
    writeIe(8'h04);
    eof(8'hD9);
    pulseSrc(5'b00100);
    eof(8'h00);
    testsRun++;
    if (bus.oIrqRequest !== 1'b1) begin testsFailed++; $display("[TB] FAIL midreset_setup got req=%b want 1", bus.oIrqRequest); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    testsRun++;
    if ({bus.oIrqRequest, bus.oIf, bus.oIe, bus.oIme, bus.oIrqVector} !== {1'b0, 8'hE0, 8'h00, 1'b0, 8'h00}) begin
      testsFailed++;
      $display("[TB] FAIL midreset got req=%b if=%h ie=%h ime=%b vec=%h want 0 e0 00 0 00",
               bus.oIrqRequest, bus.oIf, bus.oIe, bus.oIme, bus.oIrqVector);
    end
    writeIe(8'h01);
    pulseSrc(5'b00001);
    testsRun++;
    if ({bus.oWakeup, bus.oIrqRequest} !== 2'b10) begin
      testsFailed++; $display("[TB] FAIL wakeup got wake=%b req=%b want 1 0", bus.oWakeup, bus.oIrqRequest);
    end
    eof(8'h00);
    testsRun++;
    if (bus.oIrqRequest !== 1'b0) begin testsFailed++; $display("[TB] FAIL wakeup_noreq got req=%b want 0", bus.oIrqRequest); end
  endtask

  initial begin
    clearInputs();
    test_reset();
    test_timer_dispatch();
    test_priority();
    test_ei_delay();
    test_committed();
    test_set_wins();
    test_reset_mid_request();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
